// File: rtl/axis_conv_pkg.sv
// Shared constants and helpers for the AXI-Stream width converter:
// ratio/lane-index derivation, mode selection and the tkeep contiguity rule.
package axis_conv_pkg;

    typedef enum logic [1:0] {
        CONV_EQUAL,
        CONV_UP,
        CONV_DOWN,
        CONV_BAD
    } conv_mode_e;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic int conv_ratio(input int s_bytes, input int m_bytes);
        return (s_bytes > m_bytes) ? (s_bytes / m_bytes) : (m_bytes / s_bytes);
    endfunction

    function automatic int conv_idx_w(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

    // Powers of two always divide evenly, so only range and pow2-ness matter.
    function automatic conv_mode_e conv_mode(input int s_bytes, input int m_bytes);
        if (!is_pow2(s_bytes) || !is_pow2(m_bytes) || (s_bytes > 32)) return CONV_BAD;
        if (m_bytes > s_bytes) return CONV_UP;
        if (s_bytes > m_bytes) return CONV_DOWN;
        return CONV_EQUAL;
    endfunction

    // Legal keep is 0..01..1 and non-zero: adding one to a run of low ones clears them all.
    function automatic logic keep_contiguous(input logic [63:0] keep);
        return (keep != '0) && ((keep & (keep + 64'd1)) == '0);
    endfunction

endpackage

// File: rtl/axis_keep_check.sv
// Combinational tkeep checker: flags whether an input keep vector is a
// non-empty run of ones starting at byte lane 0.
module axis_keep_check
    import axis_conv_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] keep,
    output logic         keep_ok
);

    assign keep_ok = keep_contiguous(64'(keep));

endmodule

// File: rtl/axi_stream_width_converter.sv
// Parametrised AXI-Stream byte-lane width converter: packs narrow beats into wide
// ones (up), unpacks wide beats into narrow ones (down), or registers (equal).
module axi_stream_width_converter
    import axis_conv_pkg::*;
#(
    parameter int S_BYTES    = 4,
    parameter int M_BYTES    = 8,
    parameter int USER_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [S_BYTES*8-1:0]    sAxisTdata,
    input  logic [S_BYTES-1:0]      sAxisTkeep,
    input  logic [USER_WIDTH-1:0]   sAxisTuser,
    input  logic                    sAxisTlast,
    input  logic                    sAxisTvalid,
    output logic                    sAxisTready,
    output logic [M_BYTES*8-1:0]    mAxisTdata,
    output logic [M_BYTES-1:0]      mAxisTkeep,
    output logic [USER_WIDTH-1:0]   mAxisTuser,
    output logic                    mAxisTlast,
    output logic                    mAxisTvalid,
    input  logic                    mAxisTready,
    output logic                    keepErr
);

    localparam conv_mode_e MODE  = conv_mode(S_BYTES, M_BYTES);
    localparam int         RATIO = conv_ratio(S_BYTES, M_BYTES);
    localparam int         IDX_W = conv_idx_w(RATIO);

    logic keep_ok;
    logic s_hs;
    logic keep_err_q, keep_err_d;

    axis_keep_check #(.N(S_BYTES)) u_keep_check (
        .keep    (sAxisTkeep),
        .keep_ok (keep_ok)
    );

    assign s_hs    = sAxisTvalid && sAxisTready;
    assign keepErr = keep_err_q;

    always_comb begin
        keep_err_d = keep_err_q || (s_hs && !keep_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) keep_err_q <= 1'b0;
        else       keep_err_q <= keep_err_d;
    end

    if (MODE == CONV_BAD) begin : g_bad
        $error("axi_stream_width_converter: unsupported S_BYTES/M_BYTES combination");
    end else if (MODE == CONV_DOWN) begin : g_down
        localparam int MW = M_BYTES * 8;

        logic [S_BYTES*8-1:0]  buf_data_q, buf_data_d;
        logic [S_BYTES-1:0]    buf_keep_q, buf_keep_d;
        logic [USER_WIDTH-1:0] buf_user_q, buf_user_d;
        logic                  buf_last_q, buf_last_d;
        logic                  buf_valid_q, buf_valid_d;
        logic [IDX_W-1:0]      idx_q, idx_d;
        logic [MW-1:0]         slice_data;
        logic [M_BYTES-1:0]    slice_keep;
        logic                  next_zero, last_sub;

        always_comb begin
            slice_data = '0;
            slice_keep = '0;
            next_zero  = 1'b1;
            for (int s = 0; s < RATIO; s++) begin
                if (idx_q == IDX_W'(s)) begin
                    slice_data = buf_data_q[s*MW +: MW];
                    slice_keep = buf_keep_q[s*M_BYTES +: M_BYTES];
                end
            end
            // An empty following slice means this is the last useful sub-beat.
            for (int s = 1; s < RATIO; s++) begin
                if (idx_q == IDX_W'(s - 1)) next_zero = (buf_keep_q[s*M_BYTES +: M_BYTES] == '0);
            end
            last_sub = (idx_q == IDX_W'(RATIO - 1)) || next_zero;
        end

        assign sAxisTready = !buf_valid_q || (mAxisTready && last_sub);
        assign mAxisTvalid = buf_valid_q;
        assign mAxisTdata  = slice_data;
        assign mAxisTkeep  = slice_keep;
        assign mAxisTuser  = buf_user_q;
        assign mAxisTlast  = buf_last_q && last_sub;

        always_comb begin
            buf_data_d  = buf_data_q;
            buf_keep_d  = buf_keep_q;
            buf_user_d  = buf_user_q;
            buf_last_d  = buf_last_q;
            buf_valid_d = buf_valid_q;
            idx_d       = idx_q;
            if (buf_valid_q && mAxisTready) begin
                if (last_sub) begin
                    buf_valid_d = 1'b0;
                    idx_d       = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            // All-zero keep carries no bytes, so the beat is dropped outright.
            if (s_hs && (sAxisTkeep != '0)) begin
                buf_data_d  = sAxisTdata;
                buf_keep_d  = sAxisTkeep;
                buf_user_d  = sAxisTuser;
                buf_last_d  = sAxisTlast;
                buf_valid_d = 1'b1;
                idx_d       = '0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                buf_data_q  <= '0;
                buf_keep_q  <= '0;
                buf_user_q  <= '0;
                buf_last_q  <= 1'b0;
                buf_valid_q <= 1'b0;
                idx_q       <= '0;
            end else begin
                buf_data_q  <= buf_data_d;
                buf_keep_q  <= buf_keep_d;
                buf_user_q  <= buf_user_d;
                buf_last_q  <= buf_last_d;
                buf_valid_q <= buf_valid_d;
                idx_q       <= idx_d;
            end
        end
    end else begin : g_up
        // Also covers the equal-width case: RATIO==1 completes on every beat.
        localparam int SW = S_BYTES * 8;
        localparam int MW = M_BYTES * 8;

        logic [MW-1:0]         acc_data_q, acc_data_d, out_data_q, out_data_d, merged_data;
        logic [M_BYTES-1:0]    acc_keep_q, acc_keep_d, out_keep_q, out_keep_d, merged_keep;
        logic [USER_WIDTH-1:0] out_user_q, out_user_d;
        logic                  out_last_q, out_last_d;
        logic                  out_valid_q, out_valid_d;
        logic [IDX_W-1:0]      idx_q, idx_d;
        logic                  complete;

        assign sAxisTready = !out_valid_q || mAxisTready;
        assign mAxisTvalid = out_valid_q;
        assign mAxisTdata  = out_data_q;
        assign mAxisTkeep  = out_keep_q;
        assign mAxisTuser  = out_user_q;
        assign mAxisTlast  = out_last_q;

        always_comb begin
            merged_data = acc_data_q;
            merged_keep = acc_keep_q;
            for (int s = 0; s < RATIO; s++) begin
                if (idx_q == IDX_W'(s)) begin
                    merged_data[s*SW +: SW]           = sAxisTdata;
                    merged_keep[s*S_BYTES +: S_BYTES] = sAxisTkeep;
                end
            end
            complete = (idx_q == IDX_W'(RATIO - 1)) || sAxisTlast;

            acc_data_d  = acc_data_q;
            acc_keep_d  = acc_keep_q;
            out_data_d  = out_data_q;
            out_keep_d  = out_keep_q;
            out_user_d  = out_user_q;
            out_last_d  = out_last_q;
            out_valid_d = out_valid_q && !mAxisTready;
            idx_d       = idx_q;
            if (s_hs) begin
                if (complete) begin
                    // Accumulator is cleared here so unfilled slots of the next word read as zero.
                    out_data_d  = merged_data;
                    out_keep_d  = merged_keep;
                    out_user_d  = sAxisTuser;
                    out_last_d  = sAxisTlast;
                    out_valid_d = 1'b1;
                    acc_data_d  = '0;
                    acc_keep_d  = '0;
                    idx_d       = '0;
                end else begin
                    acc_data_d = merged_data;
                    acc_keep_d = merged_keep;
                    idx_d      = idx_q + IDX_W'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                acc_data_q  <= '0;
                acc_keep_q  <= '0;
                out_data_q  <= '0;
                out_keep_q  <= '0;
                out_user_q  <= '0;
                out_last_q  <= 1'b0;
                out_valid_q <= 1'b0;
                idx_q       <= '0;
            end else begin
                acc_data_q  <= acc_data_d;
                acc_keep_q  <= acc_keep_d;
                out_data_q  <= out_data_d;
                out_keep_q  <= out_keep_d;
                out_user_q  <= out_user_d;
                out_last_q  <= out_last_d;
                out_valid_q <= out_valid_d;
                idx_q       <= idx_d;
            end
        end
    end

endmodule

// File: tb/tb_axi_stream_width_converter.sv
// Bench for the width converter: a 4->8 packing instance and an 8->4 unpacking
// instance, directed cases plus a randomized unpack run against a byte-level model.
module tb_axi_stream_width_converter;

    logic clk;
    logic reset;

    logic [31:0] u_s_data;  logic [3:0] u_s_keep;  logic [7:0] u_s_user;
    logic        u_s_last, u_s_valid, u_s_ready;
    logic [63:0] u_m_data;  logic [7:0] u_m_keep;  logic [7:0] u_m_user;
    logic        u_m_last, u_m_valid, u_m_ready, u_err;

    logic [63:0] d_s_data;  logic [7:0] d_s_keep;  logic [7:0] d_s_user;
    logic        d_s_last, d_s_valid, d_s_ready;
    logic [31:0] d_m_data;  logic [3:0] d_m_keep;  logic [7:0] d_m_user;
    logic        d_m_last, d_m_valid, d_m_ready, d_err;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int chk_cnt  = 0;

    axi_stream_width_converter #(.S_BYTES(4), .M_BYTES(8), .USER_WIDTH(8)) u_up (
        .clk(clk), .reset(reset),
        .sAxisTdata(u_s_data), .sAxisTkeep(u_s_keep), .sAxisTuser(u_s_user),
        .sAxisTlast(u_s_last), .sAxisTvalid(u_s_valid), .sAxisTready(u_s_ready),
        .mAxisTdata(u_m_data), .mAxisTkeep(u_m_keep), .mAxisTuser(u_m_user),
        .mAxisTlast(u_m_last), .mAxisTvalid(u_m_valid), .mAxisTready(u_m_ready),
        .keepErr(u_err)
    );

    axi_stream_width_converter #(.S_BYTES(8), .M_BYTES(4), .USER_WIDTH(8)) u_dn (
        .clk(clk), .reset(reset),
        .sAxisTdata(d_s_data), .sAxisTkeep(d_s_keep), .sAxisTuser(d_s_user),
        .sAxisTlast(d_s_last), .sAxisTvalid(d_s_valid), .sAxisTready(d_s_ready),
        .mAxisTdata(d_m_data), .mAxisTkeep(d_m_keep), .mAxisTuser(d_m_user),
        .mAxisTlast(d_m_last), .mAxisTvalid(d_m_valid), .mAxisTready(d_m_ready),
        .keepErr(d_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        u_s_valid = 1'b0;
        d_s_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic up_step(input logic [31:0] data, input logic [3:0] keep,
                           input logic last, input logic [7:0] user);
        @(negedge clk);
        u_s_data = data; u_s_keep = keep; u_s_last = last; u_s_user = user;
        u_s_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic up_idle();
        @(negedge clk);
        u_s_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic dn_step(input logic [63:0] data, input logic [7:0] keep,
                           input logic last, input logic [7:0] user);
        @(negedge clk);
        d_s_data = data; d_s_keep = keep; d_s_last = last; d_s_user = user;
        d_s_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic dn_idle();
        @(negedge clk);
        d_s_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Randomized unpack run: input beats, and expected sub-beats {data,keep,last,user}.
    logic [63:0] in_data[$];
    logic [7:0]  in_keep[$];
    logic [7:0]  in_user[$];
    logic        in_last[$];
    logic [44:0] exp_q[$];
    logic [44:0] held, got;
    logic        stalled, accepted;
    int          ip, cyc, nb, nbytes, kb;
    logic [63:0] rdata;

    initial begin
        reset = 1'b1;
        u_s_valid = 0; u_s_data = '0; u_s_keep = '0; u_s_user = '0; u_s_last = 0; u_m_ready = 1;
        d_s_valid = 0; d_s_data = '0; d_s_keep = '0; d_s_user = '0; d_s_last = 0; d_m_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset state of both instances
        chk("rst_up_out", {u_m_valid, u_m_data, u_m_keep, u_m_user, u_m_last}, '0);
        chk("rst_up_err", u_err, 0);
        chk("rst_up_sready", u_s_ready, 1);
        chk("rst_dn_out", {d_m_valid, d_m_data, d_m_keep, d_m_user, d_m_last}, '0);
        chk("rst_dn_err", d_err, 0);
        chk("rst_dn_sready", d_s_ready, 1);

        // Four-beat pack, one output per two inputs, one cycle after the completing beat
        up_step(32'h11111111, 4'hF, 0, 8'h00);
        chk("up1_b0", u_m_valid, 0);
        up_step(32'h22222222, 4'hF, 0, 8'h00);
        chk("up1_o0", {u_m_valid, u_m_data, u_m_keep, u_m_last}, {1'b1, 64'h2222222211111111, 8'hFF, 1'b0});
        up_step(32'h33333333, 4'hF, 0, 8'h00);
        chk("up1_b2", u_m_valid, 0);
        up_step(32'h44444444, 4'hF, 1, 8'h00);
        chk("up1_o1", {u_m_valid, u_m_data, u_m_keep, u_m_last}, {1'b1, 64'h4444444433333333, 8'hFF, 1'b1});
        up_idle();
        chk("up1_end", u_m_valid, 0);

        // Three-beat frame: the short final word has keep 0x0F and zero upper data
        up_step(32'hAAAAAAAA, 4'hF, 0, 8'h01);
        up_step(32'hBBBBBBBB, 4'hF, 0, 8'h02);
        chk("up2_o0", {u_m_valid, u_m_data, u_m_keep, u_m_last, u_m_user},
            {1'b1, 64'hBBBBBBBBAAAAAAAA, 8'hFF, 1'b0, 8'h02});
        up_step(32'hCCCCCCCC, 4'hF, 1, 8'h03);
        chk("up2_o1", {u_m_valid, u_m_data, u_m_keep, u_m_last, u_m_user},
            {1'b1, 64'h00000000CCCCCCCC, 8'h0F, 1'b1, 8'h03});
        up_idle();

        // Output stall: word held stable and input back-pressured
        u_m_ready = 1'b0;
        up_step(32'h01020304, 4'hF, 0, 8'h10);
        up_step(32'h05060708, 4'hF, 0, 8'h11);
        up_idle();
        chk("up_stall0", {u_m_valid, u_m_data, u_m_keep}, {1'b1, 64'h0506070801020304, 8'hFF});
        chk("up_stall_sready", u_s_ready, 0);
        up_idle();
        chk("up_stall1", {u_m_valid, u_m_data, u_m_user}, {1'b1, 64'h0506070801020304, 8'h11});
        u_m_ready = 1'b1;
        up_idle();
        chk("up_drain", u_m_valid, 0);

        // Non-contiguous keep: passed through as given, error flag sticks
        up_step(32'h55555555, 4'h5, 1, 8'h00);
        chk("up_bad_out", {u_m_valid, u_m_data, u_m_keep}, {1'b1, 64'h0000000055555555, 8'h05});
        chk("up_bad_err", u_err, 1);
        up_step(32'h66666666, 4'hF, 0, 8'h00);
        up_step(32'h77777777, 4'hF, 1, 8'h00);
        chk("up_good_after_bad", {u_m_valid, u_m_data}, {1'b1, 64'h7777777766666666});
        up_idle();
        chk("up_err_sticky", u_err, 1);

        // Unpack with empty upper slice: one sub-beat, input ready in the same cycle
        dn_step(64'hAABBCCDD11223344, 8'h0F, 1, 8'h00);
        chk("dn3_out", {d_m_valid, d_m_data, d_m_keep, d_m_last}, {1'b1, 32'h11223344, 4'hF, 1'b1});
        chk("dn3_sready", d_s_ready, 1);
        dn_idle();
        chk("dn3_skip", d_m_valid, 0);

        // Full wide beat: two sub-beats, tuser on both, tlast on the second
        dn_step(64'h8877665544332211, 8'hFF, 1, 8'h5A);
        chk("dn_full0", {d_m_valid, d_m_data, d_m_keep, d_m_last, d_m_user},
            {1'b1, 32'h44332211, 4'hF, 1'b0, 8'h5A});
        chk("dn_full0_sready", d_s_ready, 0);
        dn_idle();
        chk("dn_full1", {d_m_valid, d_m_data, d_m_keep, d_m_last, d_m_user},
            {1'b1, 32'h88776655, 4'hF, 1'b1, 8'h5A});
        chk("dn_full1_sready", d_s_ready, 1);
        dn_idle();
        chk("dn_full_end", d_m_valid, 0);

        // All-zero keep in unpack mode: beat dropped, error flagged
        dn_step(64'h0123456789ABCDEF, 8'h00, 1, 8'h00);
        chk("dn_zero_drop", d_m_valid, 0);
        chk("dn_zero_err", d_err, 1);
        dn_idle();
        chk("dn_zero_still", d_m_valid, 0);

        // Reset mid-frame with one beat held in the accumulator
        up_step(32'hDEADBEEF, 4'hF, 0, 8'h00);
        do_reset();
        chk("rst5_valid", u_m_valid, 0);
        chk("rst5_errs", {u_err, d_err}, 2'b00);
        chk("rst5_sready", u_s_ready, 1);
        up_step(32'h0A0A0A0A, 4'hF, 0, 8'h00);
        chk("rst5_idx0", u_m_valid, 0);
        up_step(32'h0B0B0B0B, 4'hF, 1, 8'h07);
        chk("rst5_clean", {u_m_valid, u_m_data, u_m_keep, u_m_last, u_m_user},
            {1'b1, 64'h0B0B0B0B0A0A0A0A, 8'hFF, 1'b1, 8'h07});
        up_idle();

        // Reset while an output word is stalled
        u_m_ready = 1'b0;
        up_step(32'h12121212, 4'hF, 0, 8'h00);
        up_step(32'h34343434, 4'hF, 1, 8'h00);
        chk("rst_stall_pre", u_m_valid, 1);
        do_reset();
        chk("rst_stall_post", {u_m_valid, u_m_data, u_m_keep, u_m_last}, '0);
        u_m_ready = 1'b1;

        // Randomized unpack: 1000 frames, random output back-pressure and input gaps
        for (int f = 0; f < 1000; f++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                nbytes = (b == nb - 1) ? $urandom_range(1, 8) : 8;
                in_data.push_back({$urandom, $urandom});
                in_keep.push_back(8'((1 << nbytes) - 1));
                in_user.push_back(8'($urandom));
                in_last.push_back(b == nb - 1);
            end
        end
        ip = 0; cyc = 0; stalled = 0; accepted = 0;
        d_s_valid = 1'b0;
        while ((ip < in_data.size() || exp_q.size() != 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (stalled) chk("dn_stable", {d_m_data, d_m_keep, d_m_last, d_m_user}, held);
            if (accepted) d_s_valid = 1'b0;
            accepted = 1'b0;
            d_m_ready = 1'($urandom_range(0, 1));
            if (!d_s_valid && ip < in_data.size() && $urandom_range(0, 3) != 0) begin
                d_s_data = in_data[ip]; d_s_keep = in_keep[ip];
                d_s_user = in_user[ip]; d_s_last = in_last[ip];
                d_s_valid = 1'b1;
            end
            #1;
            got = {d_m_data, d_m_keep, d_m_last, d_m_user};
            if (d_m_valid && d_m_ready) begin
                if (exp_q.size() == 0) chk("dn_extra_beat", got, '1);
                else chk("dn_beat", got, exp_q.pop_front());
                stalled = 1'b0;
            end else begin
                stalled = d_m_valid;
                held = got;
            end
            if (d_s_valid && d_s_ready) begin
                // Model: split the beat's bytes into 4-byte groups, last group may be short
                nbytes = $countones(in_keep[ip]);
                rdata = in_data[ip];
                for (int j = 0; 4 * j < nbytes; j++) begin
                    kb = (nbytes - 4 * j > 4) ? 4 : nbytes - 4 * j;
                    exp_q.push_back({rdata[32*j +: 32], 4'((1 << kb) - 1),
                                     in_last[ip] && (4 * (j + 1) >= nbytes), in_user[ip]});
                end
                ip++;
                accepted = 1'b1;
            end
        end
        chk("dn_rand_all_sent", ip, in_data.size());
        chk("dn_rand_drained", exp_q.size(), 0);
        @(negedge clk);
        d_s_valid = 1'b0;
        d_m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("dn_rand_idle", d_m_valid, 0);
        chk("dn_rand_err", d_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
